// File: rtl/mfsk_tx.sv
// mfsk_tx: M-ary FSK modulator, DDS phase accumulator driving a
// quarter-wave sine ROM; frames go out MSB-first, one symbol per tone.
module mfsk_tx #(
  parameter int DATA_W          = 16,
  parameter int BITS_PER_SYM    = 2,
  parameter int SAMPLES_PER_SYM = 50,
  parameter int PHASE_W         = 16,
  parameter int FREQ_BASE       = 1311,
  parameter int FREQ_STEP       = 1311
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic signed [15:0]  tx,
  output logic                tx_flag,
  output logic                sym_strobe,
  output logic                frame_done
);

  localparam int NSYM  = DATA_W / BITS_PER_SYM;
  localparam int SYM_W = $clog2(NSYM + 1);
  localparam int SMP_W = $clog2(SAMPLES_PER_SYM + 1);

  localparam logic [SYM_W-1:0]   SYM_LAST = SYM_W'(NSYM - 1);
  localparam logic [SMP_W-1:0]   SMP_LAST = SMP_W'(SAMPLES_PER_SYM - 1);
  localparam logic [PHASE_W-1:0] BASE     = PHASE_W'(FREQ_BASE);
  localparam logic [PHASE_W-1:0] STEP     = PHASE_W'(FREQ_STEP);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // First quadrant of round(32767*sin(2*pi*k/256)), k = 0..64
  function automatic logic [15:0] quarter(input logic [6:0] i);
    logic [15:0] v;
    v = 16'd0;
    case (i)
      7'd0:  v = 16'd0;     7'd1:  v = 16'd804;   7'd2:  v = 16'd1608;
      7'd3:  v = 16'd2410;  7'd4:  v = 16'd3212;  7'd5:  v = 16'd4011;
      7'd6:  v = 16'd4808;  7'd7:  v = 16'd5602;  7'd8:  v = 16'd6393;
      7'd9:  v = 16'd7179;  7'd10: v = 16'd7962;  7'd11: v = 16'd8739;
      7'd12: v = 16'd9512;  7'd13: v = 16'd10278; 7'd14: v = 16'd11039;
      7'd15: v = 16'd11793; 7'd16: v = 16'd12539; 7'd17: v = 16'd13279;
      7'd18: v = 16'd14010; 7'd19: v = 16'd14732; 7'd20: v = 16'd15446;
      7'd21: v = 16'd16151; 7'd22: v = 16'd16846; 7'd23: v = 16'd17530;
      7'd24: v = 16'd18204; 7'd25: v = 16'd18868; 7'd26: v = 16'd19519;
      7'd27: v = 16'd20159; 7'd28: v = 16'd20787; 7'd29: v = 16'd21403;
      7'd30: v = 16'd22005; 7'd31: v = 16'd22594; 7'd32: v = 16'd23170;
      7'd33: v = 16'd23731; 7'd34: v = 16'd24279; 7'd35: v = 16'd24811;
      7'd36: v = 16'd25329; 7'd37: v = 16'd25832; 7'd38: v = 16'd26319;
      7'd39: v = 16'd26790; 7'd40: v = 16'd27245; 7'd41: v = 16'd27683;
      7'd42: v = 16'd28105; 7'd43: v = 16'd28510; 7'd44: v = 16'd28898;
      7'd45: v = 16'd29268; 7'd46: v = 16'd29621; 7'd47: v = 16'd29956;
      7'd48: v = 16'd30273; 7'd49: v = 16'd30571; 7'd50: v = 16'd30852;
      7'd51: v = 16'd31113; 7'd52: v = 16'd31356; 7'd53: v = 16'd31580;
      7'd54: v = 16'd31785; 7'd55: v = 16'd31971; 7'd56: v = 16'd32137;
      7'd57: v = 16'd32285; 7'd58: v = 16'd32412; 7'd59: v = 16'd32521;
      7'd60: v = 16'd32609; 7'd61: v = 16'd32678; 7'd62: v = 16'd32728;
      7'd63: v = 16'd32757; 7'd64: v = 16'd32767;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  function automatic logic [15:0] sine(input logic [7:0] a);
    logic [6:0]  i;
    logic [15:0] m;
    i = a[6] ? 7'd64 - {1'b0, a[5:0]} : {1'b0, a[5:0]};
    m = quarter(i);
    return a[7] ? 16'(-m) : m;
  endfunction

  logic [0:0]              state_q, state_d;
  logic [DATA_W-1:0]       shreg_q, shreg_d;
  logic [SYM_W-1:0]        sym_cnt_q, sym_cnt_d;
  logic [SMP_W-1:0]        smp_cnt_q, smp_cnt_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [15:0]             tx_q, tx_d;
  logic                    flag_q, flag_d;
  logic                    strb_q, strb_d;
  logic                    done_q, done_d;
  logic                    last;
  logic                    accept;
  logic [BITS_PER_SYM-1:0] sym;
  logic [PHASE_W-1:0]      tw;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    sym_cnt_d = sym_cnt_q;
    smp_cnt_d = smp_cnt_q;
    phase_d   = phase_q;
    last      = (state_q == SEND) && (sym_cnt_q == SYM_LAST)
                && (smp_cnt_q == SMP_LAST);
    data_ready = ~sys_rst & ((state_q == IDLE) | last);
    accept    = data_valid & data_ready;
    sym       = shreg_q[DATA_W-1 -: BITS_PER_SYM];
    tw        = BASE + PHASE_W'(sym) * STEP;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SEND;
          shreg_d   = data_in;
          sym_cnt_d = '0;
          smp_cnt_d = '0;
          phase_d   = '0;
        end
      end
      default: begin
        phase_d = phase_q + tw;
        if (smp_cnt_q == SMP_LAST) begin
          smp_cnt_d = '0;
          shreg_d   = shreg_q << BITS_PER_SYM;
          sym_cnt_d = sym_cnt_q + 1'b1;
          if (sym_cnt_q == SYM_LAST) begin
            sym_cnt_d = '0;
            // A back-to-back frame keeps the accumulated phase
            if (accept) shreg_d = data_in;
            else        state_d = IDLE;
          end
        end else begin
          smp_cnt_d = smp_cnt_q + 1'b1;
        end
      end
    endcase
    tx_d   = (state_q == SEND) ? sine(phase_q[PHASE_W-1 -: 8]) : 16'd0;
    flag_d = (state_q == SEND);
    strb_d = (state_q == SEND) && (smp_cnt_q == '0);
    done_d = last;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      sym_cnt_q <= '0;
      smp_cnt_q <= '0;
      phase_q   <= '0;
      tx_q      <= '0;
      flag_q    <= 1'b0;
      strb_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      sym_cnt_q <= sym_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      phase_q   <= phase_d;
      tx_q      <= tx_d;
      flag_q    <= flag_d;
      strb_q    <= strb_d;
      done_q    <= done_d;
    end
  end

  assign tx         = $signed(tx_q);
  assign tx_flag    = flag_q;
  assign sym_strobe = strb_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_mfsk_tx.sv
// Directed bench for mfsk_tx: frame table against a DDS/sine model,
// plus back-to-back, mid-frame reset and 1-bit-per-symbol cases.
module tb_mfsk_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [15:0]        din;
  logic               dv, dr;
  logic signed [15:0] tx;
  logic               flag, strb, done;

  logic [7:0]         din2;
  logic               dv2, dr2;
  logic signed [15:0] tx2;
  logic               flag2, strb2, done2;

  mfsk_tx dut (
    .sys_clk(clk), .sys_rst(rst), .data_in(din), .data_valid(dv),
    .data_ready(dr), .tx(tx), .tx_flag(flag), .sym_strobe(strb),
    .frame_done(done)
  );

  mfsk_tx #(.DATA_W(8), .BITS_PER_SYM(1), .SAMPLES_PER_SYM(4)) dut2 (
    .sys_clk(clk), .sys_rst(rst), .data_in(din2), .data_valid(dv2),
    .data_ready(dr2), .tx(tx2), .tx_flag(flag2), .sym_strobe(strb2),
    .frame_done(done2)
  );

  typedef struct {
    logic [15:0] data;
    int          sym[8];
  } vec_t;

  vec_t tbl[5];
  int total_n = 0;
  int bad_n   = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic int rom(input int k);
    real v;
    v = 32767.0 * $sin(2.0 * 3.141592653589793 * k / 256.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Send table frame a (and b back-to-back if b >= 0), model every sample
  task automatic run_seq(input int a, input int b, input bit scr,
                         output int ph50);
    int nfr, tot, s, f, j;
    logic [15:0] ph;
    int e_tx, e_fl, e_st, e_dn, e_rd, e_ph, n_st, n_dn, n_fl;
    int ptx;
    bit pfl, pst, pdn;
    nfr = (b >= 0) ? 2 : 1;
    tot = nfr * 400;
    ph = 16'd0;
    {e_tx, e_fl, e_st, e_dn, e_rd, e_ph, n_st, n_dn, n_fl} = '0;
    ptx = 0; pfl = 0; pst = 0; pdn = 0; ph50 = -1;
    @(negedge clk);
    check("idle_ready", dr, 1);
    dv = 1'b1;
    din = tbl[a].data;
    for (int n = 0; n <= tot; n++) begin
      @(negedge clk);
      if (int'(tx) != ptx) begin
        if (e_tx == 0)
          $display("  tx diff cycle %0d got %0d want %0d", n, tx, ptx);
        e_tx++;
      end
      if (flag !== pfl) e_fl++;
      if (strb !== pst) e_st++;
      if (done !== pdn) e_dn++;
      n_st += int'(strb);
      n_dn += int'(done);
      n_fl += int'(flag);
      if (n == tot) break;
      f = n / 400;
      j = (n % 400) / 50;
      s = (f == 0) ? tbl[a].sym[j] : tbl[b].sym[j];
      if (dr !== ((n % 400) == 399)) e_rd++;
      if (dut.phase_q !== ph) e_ph++;
      if (n == 50) ph50 = int'(dut.phase_q);
      ptx = rom(int'(ph[15:8]));
      pfl = 1'b1;
      pst = (n % 50) == 0;
      pdn = (n % 400) == 399;
      ph = ph + 16'(1311 * (s + 1));
      if ((n % 400) == 399) begin
        dv = (f == 0) && (b >= 0);
        if (dv) din = tbl[b].data;
      end else begin
        dv = scr;
        din = 16'($urandom);
      end
    end
    check("ready_after_frame", dr, 1);
    dv = 1'b0;
    @(negedge clk);
    check("tx_idle", tx, 0);
    check("flag_idle", flag, 0);
    check("phase_held", dut.phase_q, ph);
    check("tx_stream", e_tx, 0);
    check("flag_stream", e_fl, 0);
    check("strobe_stream", e_st, 0);
    check("done_stream", e_dn, 0);
    check("ready_stream", e_rd, 0);
    check("phase_stream", e_ph, 0);
    check("strobe_count", n_st, 8 * nfr);
    check("done_count", n_dn, nfr);
    check("flag_count", n_fl, tot);
  endtask

  initial begin
    int ph50, nd, nf, ptx2, e2;
    int tw2[8];
    logic [15:0] ph2;
    tbl[0] = '{16'hFEC8, '{3, 3, 3, 2, 3, 0, 2, 0}};
    tbl[1] = '{16'h7EF0, '{1, 3, 3, 2, 3, 3, 0, 0}};
    tbl[2] = '{16'h0000, '{0, 0, 0, 0, 0, 0, 0, 0}};
    tbl[3] = '{16'hFFFF, '{3, 3, 3, 3, 3, 3, 3, 3}};
    tbl[4] = '{16'h1B1B, '{0, 1, 2, 3, 0, 1, 2, 3}};
    tw2 = '{2622, 1311, 2622, 1311, 1311, 2622, 1311, 2622};

    rst = 1'b1; dv = 1'b0; din = 16'h0; dv2 = 1'b0; din2 = 8'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", dr, 0);
    check("rst_tx", tx, 0);
    check("rst_flag", flag, 0);
    check("rst_strobe", strb, 0);
    check("rst_done", done, 0);
    check("rst_phase", dut.phase_q, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", dr, 1);
    check("ready2_after_rst", dr2, 1);

    for (int i = 0; i < 5; i++) begin
      run_seq(i, -1, 1'b0, ph50);
      if (i == 0) check("phase_after_sym0", ph50, 56);
      repeat (3) @(negedge clk);
    end

    // back-to-back with data_in churning while busy
    run_seq(0, 1, 1'b1, ph50);
    repeat (2) @(negedge clk);

    // reset in the middle of a frame
    dv = 1'b1; din = 16'hFEC8;
    for (int n = 0; n <= 136; n++) begin
      @(negedge clk);
      dv = 1'b0;
      din = 16'($urandom);
    end
    check("midframe_flag", flag, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", tx, 0);
    check("abort_flag", flag, 0);
    check("abort_done", done, 0);
    check("abort_ready", dr, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_rel", dr, 1);
    nd = 0; nf = 0;
    repeat (420) begin
      @(negedge clk);
      nd += int'(done);
      nf += int'(flag);
    end
    check("abort_no_done", nd, 0);
    check("abort_no_flag", nf, 0);
    run_seq(0, -1, 1'b0, ph50);
    check("restart_phase", ph50, 56);

    // 1 bit per symbol, 4 samples per symbol, 0xA5
    @(negedge clk);
    dv2 = 1'b1; din2 = 8'hA5;
    ph2 = 16'd0; ptx2 = 0; e2 = 0; nd = 0; nf = 0;
    for (int n = 0; n <= 32; n++) begin
      @(negedge clk);
      dv2 = 1'b0;
      if (int'(tx2) != ptx2) e2++;
      if (n > 0 && strb2 !== ((n - 1) % 4 == 0)) e2++;
      nd += int'(done2);
      nf += int'(flag2);
      if (n == 32) break;
      if (dr2 !== (n == 31)) e2++;
      ptx2 = rom(int'(ph2[15:8]));
      ph2 = ph2 + 16'(tw2[n / 4]);
    end
    check("small_stream", e2, 0);
    check("small_done", nd, 1);
    check("small_flag", nf, 32);
    check("small_phase", dut2.phase_q, 62928);
    @(negedge clk);
    check("small_idle_flag", flag2, 0);
    check("small_idle_tx", tx2, 0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/mfsk_tx.md
MFSK_TX -- requirements
Module: mfsk_tx

Interface
REQ-001 Parameter DATA_W, 16, frame width in bits; SHALL be a multiple of BITS_PER_SYM.
REQ-002 Parameter BITS_PER_SYM, 2, bits per symbol (1..4); M = 2^BITS_PER_SYM tones.
REQ-003 Parameter SAMPLES_PER_SYM, 50, clock cycles per symbol (>=2).
REQ-004 Parameter PHASE_W, 16, phase accumulator width (>=8).
REQ-005 Parameter FREQ_BASE, 1311, tuning word of symbol 0.
REQ-006 Parameter FREQ_STEP, 1311, tuning-word increment per symbol value.
REQ-007 sys_clk  in  1  sole clock, all logic rising-edge.
REQ-008 sys_rst  in  1  reset, synchronous, active-high.
REQ-009 data_in  in  DATA_W  frame to transmit, MSB-first.
REQ-010 data_valid  in  1  frame offered.
REQ-011 data_ready  out  1  frame accepted when data_valid && data_ready at a rising edge.
REQ-012 tx  out  16  signed sine sample, two's complement.
REQ-013 tx_flag  out  1  high while tx carries a modulated sample.
REQ-014 sym_strobe  out  1  one-cycle pulse aligned with first tx sample of each symbol.
REQ-015 frame_done  out  1  one-cycle pulse aligned with last tx sample of a frame.

Function
REQ-016 States: IDLE, SEND; no other states.
REQ-017 data_ready SHALL be 1 in IDLE, and in SEND only during the last sample cycle of the last symbol; 0 otherwise.
REQ-018 IDLE accept: latch data_in into shift register, clear symbol and sample counters, clear phase accumulator to 0, go to SEND.
REQ-019 Accept in last SEND cycle: latch new frame, clear counters, phase accumulator NOT cleared (continuous phase), stay in SEND; no gap sample.
REQ-020 Last SEND cycle without accept: go to IDLE.
REQ-021 Symbol value s = top BITS_PER_SYM bits of shift register; shift left by BITS_PER_SYM (zero fill) after SAMPLES_PER_SYM cycles.
REQ-022 Tuning word = FREQ_BASE + s*FREQ_STEP, computed in PHASE_W bits, modulo 2^PHASE_W.
REQ-023 Each SEND cycle: phase <= phase + tuning word, wrapping modulo 2^PHASE_W; phase held in IDLE.
REQ-024 Sine ROM: 256 entries, entry k = round(32767*sin(2*pi*k/256)), addressed by phase[PHASE_W-1 -: 8].
REQ-025 tx registered: tx at edge n+1 = ROM[phase value present during SEND cycle n]; latency 1 cycle.
REQ-026 tx_flag, sym_strobe, frame_done SHALL be delayed identically so they align with tx.
REQ-027 After leaving SEND, tx SHALL be 0 and tx_flag 0 from the first cycle with no modulated sample.
REQ-028 Frame length = (DATA_W/BITS_PER_SYM)*SAMPLES_PER_SYM cycles; defaults: 8 symbols, 400 cycles.
REQ-029 data_in changes without an accept handshake SHALL have no effect on output.

Reset
REQ-030 sys_rst high at an edge: state IDLE, counters 0, shift register 0, phase 0, tx 0, tx_flag 0, sym_strobe 0, frame_done 0, data_ready 0 while sys_rst is high.
REQ-031 Reset mid-frame SHALL abort the frame immediately with no frame_done; data_ready 1 from the first edge after sys_rst falls.

Verification
REQ-032 Defaults, accept 16'hFEC8 from IDLE -> symbols 3,3,3,2,3,0,2,0; tx_flag high exactly 400 cycles; 8 sym_strobe pulses 50 cycles apart; one frame_done on sample 400; first tx = 0 (phase 0).
REQ-033 Same frame, check phase: first symbol tuning word 5244, phase after 50 cycles = 262200 mod 65536 = 56; second symbol continues from 56.
REQ-034 Second frame 16'h7EF0 held valid through frame 1 -> accepted on cycle 400, no idle gap, phase not reset, tx_flag stays high 800 cycles, two frame_done pulses.
REQ-035 sys_rst asserted at sample 137 -> next cycle tx 0, tx_flag 0, no frame_done; new accept after release restarts at phase 0.
REQ-036 BITS_PER_SYM=1, SAMPLES_PER_SYM=4, DATA_W=8, frame 8'hA5 -> tuning words alternate 2622,1311,2622,1311,1311,2622,1311,2622; 32-cycle frame.
REQ-037 data_valid held high with data_in changing while busy -> only values present at handshake edges transmitted.
